// File: rtl/ppl_pkg.sv
// Shared widths, frame-size helper and frame FSM encoding for the ray-pipeline pixel sink.
package ppl_pkg;

    localparam int FB_ADDR_W  = 20;
    localparam int TEX_ADDR_W = 13;
    localparam int TEXEL_W    = 16;

    typedef enum logic {
        WAIT_FIRST = 1'b0,
        IN_FRAME   = 1'b1
    } frame_state_t;

    function automatic int unsigned FRAME_PIXELS(input int unsigned h, input int unsigned v);
        return h * v;
    endfunction

endpackage

// File: rtl/ppl_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered head; push while full is
// accepted when a pop happens in the same cycle.
module ppl_sync_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_next;
    logic [AW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign rd_next = pop_ok ? rd_ptr + 1'b1 : rd_ptr;
    assign level   = count;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Head register is loaded with whatever becomes the head next cycle, bypassing din
    // when the incoming word lands directly at the new head slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr <= rd_next;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            dout <= (push_ok && (wr_ptr == rd_next)) ? din : mem[rd_next];
        end
    end

endmodule

// File: rtl/ppl_pixel_sink.sv
// Pixel sink: fetches the texel for each pipeline result, buffers {addr, texel} and drains it
// to the framebuffer write port, tracking drops and frame completion.
module ppl_pixel_sink
    import ppl_pkg::*;
#(
    parameter int H_DISP     = 1280,
    parameter int V_DISP     = 720,
    parameter int FIFO_DEPTH = 16,
    parameter int TEX_LAT    = 1
) (
    input  logic                            clk_ppl,
    input  logic                            rst,
    input  logic                            valid_in,
    input  logic [FB_ADDR_W-1:0]            pixel_addr_in,
    input  logic [TEX_ADDR_W-1:0]           texture_addr_in,
    output logic                            tex_rd_en,
    output logic [TEX_ADDR_W-1:0]           tex_rd_addr,
    input  logic [TEXEL_W-1:0]              tex_rd_data,
    output logic                            fb_wr_valid,
    input  logic                            fb_wr_ready,
    output logic [FB_ADDR_W-1:0]            fb_wr_addr,
    output logic [TEXEL_W-1:0]              fb_wr_data,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            overflow,
    output logic [15:0]                     drop_cnt,
    output logic                            frame_done
);

    localparam int unsigned           FRAME_PX  = FRAME_PIXELS(H_DISP, V_DISP);
    localparam logic [FB_ADDR_W-1:0]  LAST_ADDR = FB_ADDR_W'(FRAME_PX - 1);

    logic                 vld_p0, vld_p1;
    logic [FB_ADDR_W-1:0] addr_p0, addr_p1;
    logic                 vld_al;
    logic [FB_ADDR_W-1:0] addr_al;
    logic                 in_range;
    logic                 push_req;
    logic                 pop;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 drop;
    frame_state_t         state_q, state_d;

    assign tex_rd_en   = valid_in;
    assign tex_rd_addr = texture_addr_in;

    // Stage p0/p1: delay the pixel address to line up with the ROM read data
    always_ff @(posedge clk_ppl) begin
        if (rst) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p0 <= valid_in;
            vld_p1 <= vld_p0;
        end
    end

    always_ff @(posedge clk_ppl) begin
        addr_p0 <= pixel_addr_in;
        addr_p1 <= addr_p0;
    end

    assign vld_al   = (TEX_LAT == 2) ? vld_p1 : vld_p0;
    assign addr_al  = (TEX_LAT == 2) ? addr_p1 : addr_p0;
    assign in_range = ({{(32-FB_ADDR_W){1'b0}}, addr_al} < FRAME_PX);
    assign push_req = vld_al && in_range;

    assign fb_wr_valid = !fifo_empty;
    assign pop         = fb_wr_valid && fb_wr_ready;
    assign drop        = push_req && fifo_full && !pop;

    ppl_sync_fifo #(
        .WIDTH (FB_ADDR_W + TEXEL_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_ppl),
        .rst   (rst),
        .push  (push_req),
        .din   ({addr_al, tex_rd_data}),
        .pop   (pop),
        .dout  ({fb_wr_addr, fb_wr_data}),
        .empty (fifo_empty),
        .full  (fifo_full),
        .level (fifo_level)
    );

    always_ff @(posedge clk_ppl) begin
        if (rst) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_ppl) begin
        if (rst) begin
            state_q <= WAIT_FIRST;
        end else begin
            state_q <= state_d;
        end
    end

    // Address 0 while already in a frame simply restarts it; only IN_FRAME can complete.
    always_comb begin
        state_d    = state_q;
        frame_done = 1'b0;
        case (state_q)
            WAIT_FIRST: begin
                if (pop && (fb_wr_addr == '0)) begin
                    state_d = IN_FRAME;
                end
            end
            IN_FRAME: begin
                if (pop && (fb_wr_addr == LAST_ADDR)) begin
                    state_d    = WAIT_FIRST;
                    frame_done = 1'b1;
                end
            end
            default: state_d = WAIT_FIRST;
        endcase
    end

endmodule

// File: tb/tb_ppl_pixel_sink.sv
// Directed bench for ppl_pixel_sink: full-size instance plus a 4x2-frame instance sharing stimulus.
module tb_ppl_pixel_sink;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [19:0] pixel_addr_in;
    logic [12:0] texture_addr_in;
    logic [15:0] tex_rd_data = '0;
    logic        fb_wr_ready;

    logic        tex_rd_en;
    logic [12:0] tex_rd_addr;
    logic        fb_wr_valid;
    logic [19:0] fb_wr_addr;
    logic [15:0] fb_wr_data;
    logic [4:0]  fifo_level;
    logic        overflow;
    logic [15:0] drop_cnt;
    logic        frame_done;

    logic        s_tex_rd_en;
    logic [12:0] s_tex_rd_addr;
    logic        s_fb_wr_valid;
    logic [19:0] s_fb_wr_addr;
    logic [15:0] s_fb_wr_data;
    logic [4:0]  s_fifo_level;
    logic        s_overflow;
    logic [15:0] s_drop_cnt;
    logic        s_frame_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [15:0] rom(input logic [12:0] a);
        if (a == 13'h123) return 16'hF800;
        return 16'hA5A5 ^ {3'b000, a};
    endfunction

    always_ff @(posedge clk) begin
        if (tex_rd_en) tex_rd_data <= rom(tex_rd_addr);
    end

    ppl_pixel_sink dut (
        .clk_ppl(clk), .rst(rst), .valid_in(valid_in), .pixel_addr_in(pixel_addr_in),
        .texture_addr_in(texture_addr_in), .tex_rd_en(tex_rd_en), .tex_rd_addr(tex_rd_addr),
        .tex_rd_data(tex_rd_data), .fb_wr_valid(fb_wr_valid), .fb_wr_ready(fb_wr_ready),
        .fb_wr_addr(fb_wr_addr), .fb_wr_data(fb_wr_data), .fifo_level(fifo_level),
        .overflow(overflow), .drop_cnt(drop_cnt), .frame_done(frame_done)
    );

    ppl_pixel_sink #(.H_DISP(4), .V_DISP(2)) dut_small (
        .clk_ppl(clk), .rst(rst), .valid_in(valid_in), .pixel_addr_in(pixel_addr_in),
        .texture_addr_in(texture_addr_in), .tex_rd_en(s_tex_rd_en), .tex_rd_addr(s_tex_rd_addr),
        .tex_rd_data(tex_rd_data), .fb_wr_valid(s_fb_wr_valid), .fb_wr_ready(fb_wr_ready),
        .fb_wr_addr(s_fb_wr_addr), .fb_wr_data(s_fb_wr_data), .fifo_level(s_fifo_level),
        .overflow(s_overflow), .drop_cnt(s_drop_cnt), .frame_done(s_frame_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          pulses;
        int          writes;
        int          nxt;
        int          stale;
        logic [19:0] pulse_addr;
        logic [19:0] held_addr;
        logic [15:0] held_data;
        logic        prev_stall;

        rst = 1'b1; valid_in = 1'b0; pixel_addr_in = '0; texture_addr_in = '0; fb_wr_ready = 1'b0;
        tick(); tick();
        check("rst_valid", 32'(fb_wr_valid), 0);
        check("rst_level", 32'(fifo_level), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_drop_cnt", 32'(drop_cnt), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_addr", 32'(fb_wr_addr), 0);
        check("rst_data", 32'(fb_wr_data), 0);
        rst = 1'b0;
        tick();

        // single pixel, latency TEX_LAT+1
        fb_wr_ready = 1'b1;
        valid_in = 1'b1; pixel_addr_in = 20'h00005; texture_addr_in = 13'h0123;
        #1;
        check("fetch_en", 32'(tex_rd_en), 1);
        check("fetch_addr", 32'(tex_rd_addr), 32'h123);
        tick();
        valid_in = 1'b0;
        check("single_not_yet", 32'(fb_wr_valid), 0);
        tick();
        check("single_valid", 32'(fb_wr_valid), 1);
        check("single_addr", 32'(fb_wr_addr), 32'h5);
        check("single_data", 32'(fb_wr_data), 32'hF800);
        tick();
        check("single_popped", 32'(fb_wr_valid), 0);
        check("single_level", 32'(fifo_level), 0);

        // overflow: 20 pixels into a 16-deep FIFO with ready low
        fb_wr_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            valid_in = 1'b1; pixel_addr_in = 20'h100 + 20'(i); texture_addr_in = 13'(i);
            tick();
        end
        valid_in = 1'b0;
        tick(); tick();
        check("full_level", 32'(fifo_level), 16);
        check("full_overflow", 32'(overflow), 1);
        check("full_drop_cnt", 32'(drop_cnt), 4);
        check("full_head_addr", 32'(fb_wr_addr), 32'h100);
        check("full_head_data", 32'(fb_wr_data), 32'(rom(13'h0)));
        check("small_filtered_drop", 32'(s_drop_cnt), 0);
        check("small_filtered_level", 32'(s_fifo_level), 0);

        // full FIFO with simultaneous push and pop
        valid_in = 1'b1; pixel_addr_in = 20'h200; texture_addr_in = 13'h20;
        tick();
        valid_in = 1'b0; fb_wr_ready = 1'b1;
        check("pp_head_addr", 32'(fb_wr_addr), 32'h100);
        tick();
        fb_wr_ready = 1'b0;
        check("pp_level", 32'(fifo_level), 16);
        check("pp_overflow", 32'(overflow), 1);
        check("pp_drop_cnt", 32'(drop_cnt), 4);
        check("pp_head_addr_next", 32'(fb_wr_addr), 32'h101);

        fb_wr_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            check("drain_valid", 32'(fb_wr_valid), 1);
            check("drain_addr", 32'(fb_wr_addr), (k < 15) ? 32'h101 + 32'(k) : 32'h200);
            check("drain_data", 32'(fb_wr_data),
                  (k < 15) ? 32'(rom(13'(1 + k))) : 32'(rom(13'h20)));
            tick();
        end
        check("drain_empty", 32'(fb_wr_valid), 0);
        check("drain_level", 32'(fifo_level), 0);
        fb_wr_ready = 1'b0;

        // reset clears sticky overflow/drop count; then small-frame completion
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2_overflow", 32'(overflow), 0);
        check("rst2_drop_cnt", 32'(drop_cnt), 0);
        fb_wr_ready = 1'b1;
        pulses = 0; writes = 0; pulse_addr = '1;
        for (int c = 0; c < 20; c++) begin
            if (s_fb_wr_valid && fb_wr_ready) writes++;
            if (s_frame_done) begin
                pulses++;
                pulse_addr = s_fb_wr_addr;
            end
            if (c < 8) begin
                valid_in = 1'b1; pixel_addr_in = 20'(c); texture_addr_in = 13'(c);
            end else if (c == 8) begin
                valid_in = 1'b1; pixel_addr_in = 20'd9; texture_addr_in = 13'd9;
            end else begin
                valid_in = 1'b0;
            end
            tick();
        end
        check("frame_pulses", 32'(pulses), 1);
        check("frame_pulse_addr", 32'(pulse_addr), 7);
        check("frame_writes", 32'(writes), 8);
        check("frame_oor_drop", 32'(s_drop_cnt), 0);
        check("frame_oor_overflow", 32'(s_overflow), 0);
        check("frame_oor_level", 32'(s_fifo_level), 0);

        // random ready stalls: stability and ordering
        nxt = 0; prev_stall = 1'b0; held_addr = '0; held_data = '0;
        for (int cyc = 0; cyc < 300 && (nxt < 12 || cyc < 12); cyc++) begin
            fb_wr_ready = 1'($urandom_range(0, 1));
            if (prev_stall) begin
                check("stall_addr_stable", 32'(fb_wr_addr), 32'(held_addr));
                check("stall_data_stable", 32'(fb_wr_data), 32'(held_data));
            end
            if (fb_wr_valid && fb_wr_ready) begin
                check("stall_order_addr", 32'(fb_wr_addr), 32'h300 + 32'(3 * nxt));
                check("stall_order_data", 32'(fb_wr_data), 32'(rom(13'(32'h40 + nxt))));
                nxt++;
            end
            prev_stall = fb_wr_valid && !fb_wr_ready;
            held_addr  = fb_wr_addr;
            held_data  = fb_wr_data;
            if (cyc < 12) begin
                valid_in = 1'b1; pixel_addr_in = 20'h300 + 20'(3 * cyc); texture_addr_in = 13'(32'h40 + cyc);
            end else begin
                valid_in = 1'b0;
            end
            tick();
        end
        check("stall_count", 32'(nxt), 12);
        fb_wr_ready = 1'b0;

        // reset with entries in flight
        for (int k = 0; k < 5; k++) begin
            valid_in = 1'b1; pixel_addr_in = 20'h400 + 20'(k); texture_addr_in = 13'(k);
            tick();
        end
        valid_in = 1'b0;
        check("inflight_level", 32'(fifo_level), 4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst3_valid", 32'(fb_wr_valid), 0);
        check("rst3_level", 32'(fifo_level), 0);
        check("rst3_overflow", 32'(overflow), 0);
        check("rst3_drop_cnt", 32'(drop_cnt), 0);
        fb_wr_ready = 1'b1;
        stale = 0;
        for (int k = 0; k < 6; k++) begin
            if (fb_wr_valid) stale++;
            tick();
        end
        check("rst3_no_stale", 32'(stale), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ppl_pixel_sink.md
Name: ppl_pixel_sink

Overview:
- Consumer end of the ray-pipeline pixel output stream: takes each valid pixel result (pixel address plus texture address) and fetches the texel from the texture ROM.
- Pairs the texel with its pixel address, buffers the pair in a FIFO, and drains it to the framebuffer write port under a valid/ready handshake.
- Absorbs the pipeline's lack of backpressure and reports drops and frame completion.
- Sits between the ray pipeline top and the framebuffer/DDR write arbiter, in the clk_ppl domain.

Parameters:
- H_DISP, 1280, horizontal resolution; frame size is H_DISP*V_DISP pixels.
- V_DISP, 720, vertical resolution.
- FIFO_DEPTH, 16, entries in the pixel FIFO; must be a power of two, at least 4.
- TEX_LAT, 1, texture ROM read latency in cycles; legal values are 1 and 2.

Ports:
- clk_ppl  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- valid_in  in  1  pixel result valid; no backpressure
- pixel_addr_in  in  20  linear framebuffer address of the result
- texture_addr_in  in  13  texel address for the result
- tex_rd_en  out  1  texture ROM read enable
- tex_rd_addr  out  13  texture ROM address
- tex_rd_data  in  16  RGB565 texel; valid TEX_LAT cycles after tex_rd_en
- fb_wr_valid  out  1  framebuffer write request
- fb_wr_ready  in  1  framebuffer accepts the write
- fb_wr_addr  out  20  write address
- fb_wr_data  out  16  write data, RGB565
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- overflow  out  1  sticky; set when a pixel is dropped because the FIFO is full
- drop_cnt  out  16  count of dropped pixels; saturates at 0xFFFF
- frame_done  out  1  one-cycle pulse when the last pixel of a frame is accepted

Behaviour:
- Reset (synchronous, active-high): every output is 0, the FIFO is emptied, the delay line is cleared, and the FSM goes to WAIT_FIRST.
- Reset mid-operation discards everything in flight; no partial write survives reset.
- Reset takes priority over all other events in the same cycle.
- Fetch stage:
  - tex_rd_en = valid_in and tex_rd_addr = texture_addr_in, both combinational.
  - valid_in and pixel_addr_in pass through a TEX_LAT-deep register delay line, so the delayed pair aligns with tex_rd_data.
- Range filter: a delayed pixel with addr >= H_DISP*V_DISP is discarded silently. It is not counted and does not set overflow.
- Push rule: the aligned {addr, tex_rd_data} pair is pushed when its delayed valid is 1.
  - Full and no pop this cycle: drop the pair, set overflow, increment drop_cnt (saturating).
  - Full with a simultaneous pop: the push is accepted and the level is unchanged.
- Output handshake:
  - fb_wr_valid = FIFO non-empty; fb_wr_addr and fb_wr_data come from the FIFO head.
  - Pop occurs on fb_wr_valid & fb_wr_ready.
  - While valid and not ready, addr and data are held stable.
  - fb_wr_ready high with the FIFO empty has no effect.
- FIFO: registered read, first-word-fall-through.
  - Push to an empty FIFO makes fb_wr_valid rise on the next cycle; minimum latency from valid_in to fb_wr_valid is TEX_LAT+1 cycles.
  - fifo_level updates one cycle after the push/pop event.
- Frame FSM:
  - WAIT_FIRST -> IN_FRAME when a write with fb_wr_addr == 0 is accepted.
  - IN_FRAME -> WAIT_FIRST when a write with addr == H_DISP*V_DISP-1 is accepted; frame_done pulses that same cycle.
  - A last-address write accepted in WAIT_FIRST does not pulse frame_done.
  - An addr == 0 write accepted in IN_FRAME restarts the frame; it stays in IN_FRAME with no pulse.
- Widths: FIFO entries are 36 bits (20 address + 16 data); all comparisons are unsigned.

Decomposition:
- Shared package ppl_pkg holds:
  - FB_ADDR_W=20, TEX_ADDR_W=13, TEXEL_W=16;
  - FRAME_PIXELS(H,V) localparam function;
  - frame FSM state encoding {WAIT_FIRST, IN_FRAME}.
- One sub-module, ppl_sync_fifo:
  - parameters WIDTH, DEPTH;
  - ports push, din, pop, dout, empty, full, level;
  - simultaneous push/pop when full is legal.
- Delay line, range filter, counters and FSM stay in ppl_pixel_sink.

Test Plan:
- TEX_LAT=1, fb_wr_ready=1; single valid_in with pixel_addr_in=0x00005, texture_addr_in=0x0123, ROM[0x0123]=0xF800 -> tex_rd_addr=0x0123 in the same cycle; fb_wr_valid on cycle +2 with addr 0x00005, data 0xF800, accepted in one cycle.
- fb_wr_ready=0; 20 consecutive valids (DEPTH=16) -> fifo_level=16, overflow=1, drop_cnt=4; raising ready drains exactly the first 16 addresses in order.
- FIFO full; ready=1 and a new valid arrive in the same cycle -> push accepted, fifo_level stays 16, overflow unchanged, drop_cnt unchanged.
- H_DISP=4, V_DISP=2 (small parameters): stream addresses 0..7 -> frame_done pulses exactly once, on acceptance of addr 7; then addr 9 -> no write issued, drop_cnt unchanged.
- Random fb_wr_ready stall pattern -> fb_wr_addr and fb_wr_data remain stable whenever valid&!ready; the output sequence matches the input sequence exactly.
- rst asserted for one cycle with 5 entries in flight -> next cycle fb_wr_valid=0, fifo_level=0, overflow=0, drop_cnt=0; no stale write appears afterward.
